search_sweep_ctrl: RTL and testbench

//  Sequences the search core across a range of offsets without per-step bus traffic.
//  For each offset: resets the core, issues one seq beat, waits for the e result, tracks the minimum.

---
 rtl/search_sweep_ctrl_if.sv | 19 +
 rtl/search_sweep_ctrl.sv | 121 ++++++++++++
 tb/tb_search_sweep_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/search_sweep_ctrl_if.sv
// search_sweep_ctrl_if: seq/e handshake bundle between the sweep controller and the search core
//   master (controller): drives o_core_rst, o_offset, o_seq, o_valid, o_ready
//   slave  (core):       drives i_ready, i_e, i_valid
interface search_sweep_ctrl_if #(
   parameter int SEQ_WIDTH = 8,
   parameter int E_WIDTH   = 16,
   parameter int OFS_WIDTH = 7
);
   logic                 o_core_rst;
   logic [OFS_WIDTH-1:0] o_offset;
   logic [SEQ_WIDTH-1:0] o_seq;
   logic                 o_valid;
   logic                 i_ready;
   logic [E_WIDTH-1:0]   i_e;
   logic                 i_valid;
   logic                 o_ready;
   modport master (output o_core_rst, o_offset, o_seq, o_valid, o_ready, input i_ready, i_e, i_valid);
   modport slave  (input o_core_rst, o_offset, o_seq, o_valid, o_ready, output i_ready, i_e, i_valid);
endinterface

// File: rtl/search_sweep_ctrl.sv
// search_sweep_ctrl: steps the search core over an offset range and keeps the minimum e result
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   i_start, i_abort             sweep start / cancel pulses
//   i_ofs_first, i_ofs_last, i_seq  sweep range (inclusive) and seq beat, sampled at i_start
//   o_busy, o_done               sweep in progress / one-cycle completion pulse
//   o_best_e, o_best_ofs, o_count   minimum e, its offset, results collected
//   o_timeout                    sticky step timeout (only with SWEEP_TIMEOUT_EN, else 0)
//   core                         seq/e handshake to the core (search_sweep_ctrl_if.master)
// Optional feature macro: SWEEP_TIMEOUT_EN adds the TIMEOUT_CYCLES parameter and a WAIT-state limit.
module search_sweep_ctrl #(
   parameter int SEQ_WIDTH  = 8,
   parameter int E_WIDTH    = 16,
   parameter int OFS_WIDTH  = 7,
   parameter int RST_CYCLES = 2
`ifdef SWEEP_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 255
`endif
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_ni,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic [OFS_WIDTH-1:0] i_ofs_first,
   input  logic [OFS_WIDTH-1:0] i_ofs_last,
   input  logic [SEQ_WIDTH-1:0] i_seq,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [E_WIDTH-1:0]   o_best_e,
   output logic [OFS_WIDTH-1:0] o_best_ofs,
   output logic [OFS_WIDTH:0]   o_count,
   output logic                 o_timeout,
   search_sweep_ctrl_if.master  core
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RST   = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam int RW = $clog2(RST_CYCLES + 1);
   localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
   logic [2:0]           state;
   logic [RW-1:0]        rst_cnt;
   logic [OFS_WIDTH-1:0] ofs_last;
   logic                 abort_rst;
   logic                 timeout_hit;
   logic                 step;
   logic [E_WIDTH-1:0]   e_eff;
   assign core.o_core_rst = (state == S_RST) | abort_rst;
   assign core.o_valid    = state == S_ISSUE;
   assign core.o_ready    = state == S_WAIT;
   assign o_busy          = state != S_IDLE;
   assign o_done          = state == S_DONE;
   // A timed-out step is scored as all ones, which can never beat the current best.
   assign step  = (state == S_WAIT) & (core.i_valid | timeout_hit);
   assign e_eff = core.i_valid ? core.i_e : '1;
`ifdef SWEEP_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wait_cnt;
   // Held at zero outside WAIT, so it is already clear on WAIT entry.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
      if (!wb_rst_ni) wait_cnt <= '0;
      else wait_cnt <= (state == S_WAIT) ? wait_cnt + TW'(1) : '0;
   assign timeout_hit = wait_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
   assign timeout_hit = 1'b0;
`endif
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state         <= S_IDLE;
         rst_cnt       <= '0;
         ofs_last      <= '0;
         abort_rst     <= 1'b0;
         core.o_offset <= '0;
         core.o_seq    <= '0;
         o_best_e      <= '1;
         o_best_ofs    <= '0;
         o_count       <= '0;
         o_timeout     <= 1'b0;
      end else begin
         abort_rst <= 1'b0;
         if (i_abort && state != S_IDLE) begin
            state     <= S_IDLE;
            abort_rst <= 1'b1;
         end else begin
            case (state)
               S_IDLE: if (i_start) begin
                  core.o_seq    <= i_seq;
                  core.o_offset <= i_ofs_first;
                  ofs_last      <= i_ofs_last;
                  rst_cnt       <= '0;
                  o_count       <= '0;
                  o_timeout     <= 1'b0;
                  o_best_e      <= '1;
                  o_best_ofs    <= i_ofs_first;
                  state         <= (i_ofs_first > i_ofs_last) ? S_DONE : S_RST;
               end
               S_RST: begin
                  rst_cnt <= (rst_cnt == RST_LAST) ? '0 : rst_cnt + RW'(1);
                  if (rst_cnt == RST_LAST) state <= S_ISSUE;
               end
               S_ISSUE: if (core.i_ready) state <= S_WAIT;
               S_WAIT: if (step) begin
                  o_count <= o_count + (OFS_WIDTH+1)'(1);
                  if (!core.i_valid) o_timeout <= 1'b1;
                  if (e_eff < o_best_e) begin
                     o_best_e   <= e_eff;
                     o_best_ofs <= core.o_offset;
                  end
                  // Equality exit keeps the offset from wrapping at the top of the range.
                  if (core.o_offset == ofs_last) state <= S_DONE;
                  else begin
                     core.o_offset <= core.o_offset + OFS_WIDTH'(1);
                     state         <= S_RST;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_search_sweep_ctrl.sv
// tb_search_sweep_ctrl: scoreboard bench for search_sweep_ctrl with a table-driven core model
module tb_search_sweep_ctrl;
   typedef struct {
      logic [7:0]  count;
      logic [15:0] e;
      logic [6:0]  ofs;
      logic        to;
   } exp_t;
   logic        clk, rst_n, start, abort_p;
   logic [6:0]  ofs_first, ofs_last;
   logic [7:0]  seq;
   logic        busy, done, timeout;
   logic [15:0] best_e;
   logic [6:0]  best_ofs;
   logic [7:0]  count;
   logic [15:0] core_e [128];
   bit          silent [128];
   bit          ready_en;
   logic [7:0]  exp_seq;
   int          xfers, seq_err, rst_rises, rst_cycles, done_cnt, valid_seen;
   logic        prev_rst;
   int          passed, total;
   exp_t        sb[$];
   search_sweep_ctrl_if core_if ();
   search_sweep_ctrl #(
      .RST_CYCLES(2)
`ifdef SWEEP_TIMEOUT_EN
      , .TIMEOUT_CYCLES(4)
`endif
   ) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .i_start(start), .i_abort(abort_p),
      .i_ofs_first(ofs_first), .i_ofs_last(ofs_last), .i_seq(seq),
      .o_busy(busy), .o_done(done), .o_best_e(best_e), .o_best_ofs(best_ofs),
      .o_count(count), .o_timeout(timeout), .core(core_if)
   );
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   // Core model and monitor: sample on the falling edge, then drive for the next rising edge.
   initial begin
      core_if.i_ready = 0;
      core_if.i_valid = 0;
      core_if.i_e = '0;
      prev_rst = 0;
      forever begin
         @(negedge clk);
         core_if.i_ready = ready_en;
         core_if.i_valid = core_if.o_ready && !silent[core_if.o_offset];
         core_if.i_e = core_if.i_valid ? core_e[core_if.o_offset] : 16'h0;
         if (core_if.o_valid && core_if.i_ready) begin
            xfers++;
            if (core_if.o_seq !== exp_seq) seq_err++;
         end
         if (core_if.o_valid) valid_seen++;
         if (core_if.o_core_rst) rst_cycles++;
         if (core_if.o_core_rst && !prev_rst) rst_rises++;
         prev_rst = core_if.o_core_rst;
         if (done) done_cnt++;
      end
   end
   task automatic push_exp(input int first, input int last);
      exp_t x;
      x.count = 0;
      x.e = 16'hFFFF;
      x.ofs = 7'(first);
      x.to = 0;
      for (int o = first; o <= last; o++) begin
         logic [15:0] e;
         e = silent[o] ? 16'hFFFF : core_e[o];
         x.to = x.to | silent[o];
         x.count++;
         if (e < x.e) begin
            x.e = e;
            x.ofs = 7'(o);
         end
      end
      sb.push_back(x);
   endtask
   task automatic clear_mon();
      xfers = 0; seq_err = 0; rst_rises = 0; rst_cycles = 0; done_cnt = 0; valid_seen = 0;
   endtask
   task automatic start_sweep(input int first, input int last, input logic [7:0] s);
      @(negedge clk);
      ofs_first = 7'(first);
      ofs_last = 7'(last);
      seq = s;
      exp_seq = s;
      start = 1;
      @(negedge clk);
      start = 0;
   endtask
   task automatic wait_done(input int budget, output bit ok);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      ok = done === 1'b1;
   endtask
   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
      total++; if (best_e !== 16'hFFFF) $display("FAIL reset_best_e got %h want ffff", best_e); else passed++;
      total++; if (best_ofs !== 7'd0) $display("FAIL reset_best_ofs got %0d want 0", best_ofs); else passed++;
      total++; if (count !== 8'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
      total++; if (timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", timeout); else passed++;
      total++; if (core_if.o_core_rst !== 1'b0) $display("FAIL reset_core_rst got %b want 0", core_if.o_core_rst); else passed++;
      total++; if ({core_if.o_valid, core_if.o_ready} !== 2'b00) $display("FAIL reset_handshake got %b want 00", {core_if.o_valid, core_if.o_ready}); else passed++;
      total++; if ({core_if.o_offset, core_if.o_seq} !== 15'd0) $display("FAIL reset_ofs_seq got %h want 0", {core_if.o_offset, core_if.o_seq}); else passed++;
      rst_n = 1;
      repeat (2) @(negedge clk);
   endtask
   task automatic test_basic();
      exp_t x;
      bit ok;
      core_e[3] = 16'd40; core_e[4] = 16'd12; core_e[5] = 16'd12;
      clear_mon();
      push_exp(3, 5);
      start_sweep(3, 5, 8'hA5);
      total++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else passed++;
      wait_done(200, ok);
      total++; if (!ok) $display("FAIL basic_done_seen got 0 want 1"); else passed++;
      x = sb.pop_front();
      total++; if (count !== x.count) $display("FAIL basic_count got %0d want %0d", count, x.count); else passed++;
      total++; if (best_e !== x.e) $display("FAIL basic_best_e got %0d want %0d", best_e, x.e); else passed++;
      total++; if (best_ofs !== x.ofs) $display("FAIL basic_best_ofs got %0d want %0d", best_ofs, x.ofs); else passed++;
      total++; if (timeout !== x.to) $display("FAIL basic_timeout got %b want %b", timeout, x.to); else passed++;
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b0) $display("FAIL basic_idle got %b want 0", busy); else passed++;
      total++; if (rst_rises !== 3) $display("FAIL basic_core_resets got %0d want 3", rst_rises); else passed++;
      total++; if (rst_cycles !== 6) $display("FAIL basic_rst_cycles got %0d want 6", rst_cycles); else passed++;
      total++; if (done_cnt !== 1) $display("FAIL basic_done_pulses got %0d want 1", done_cnt); else passed++;
      total++; if (xfers !== 3 || seq_err !== 0) $display("FAIL basic_xfers got %0d/%0d want 3/0", xfers, seq_err); else passed++;
      total++; if (best_e !== x.e) $display("FAIL basic_hold got %0d want %0d", best_e, x.e); else passed++;
   endtask
   task automatic test_top_offset();
      exp_t x;
      bit ok;
      core_e[127] = 16'd7;
      clear_mon();
      push_exp(127, 127);
      start_sweep(127, 127, 8'h11);
      wait_done(100, ok);
      total++; if (!ok) $display("FAIL top_done_seen got 0 want 1"); else passed++;
      x = sb.pop_front();
      total++; if (count !== x.count) $display("FAIL top_count got %0d want %0d", count, x.count); else passed++;
      total++; if (best_e !== x.e || best_ofs !== x.ofs) $display("FAIL top_best got %0d@%0d want %0d@%0d", best_e, best_ofs, x.e, x.ofs); else passed++;
      repeat (3) @(negedge clk);
      total++; if (core_if.o_offset !== 7'd127) $display("FAIL top_no_wrap got %0d want 127", core_if.o_offset); else passed++;
      total++; if (rst_rises !== 1 || xfers !== 1) $display("FAIL top_steps got %0d/%0d want 1/1", rst_rises, xfers); else passed++;
   endtask
   task automatic test_empty_range();
      exp_t x;
      clear_mon();
      push_exp(9, 2);
      start_sweep(9, 2, 8'h22);
      x = sb.pop_front();
      total++; if (done !== 1'b1) $display("FAIL empty_done got %b want 1", done); else passed++;
      total++; if (count !== x.count) $display("FAIL empty_count got %0d want %0d", count, x.count); else passed++;
      total++; if (best_e !== x.e) $display("FAIL empty_best_e got %h want %h", best_e, x.e); else passed++;
      @(negedge clk);
      total++; if ({done, busy} !== 2'b00) $display("FAIL empty_after got %b want 00", {done, busy}); else passed++;
      repeat (2) @(negedge clk);
      total++; if (valid_seen !== 0 || rst_rises !== 0) $display("FAIL empty_core_activity got %0d/%0d want 0/0", valid_seen, rst_rises); else passed++;
   endtask
   task automatic test_backpressure();
      exp_t x;
      bit ok;
      int n, bad;
      core_e[20] = 16'd100;
      clear_mon();
      ready_en = 0;
      push_exp(20, 20);
      start_sweep(20, 20, 8'h3C);
      n = 0;
      while (core_if.o_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++; if (core_if.o_valid !== 1'b1) $display("FAIL bp_valid_rise got %b want 1", core_if.o_valid); else passed++;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (core_if.o_valid !== 1'b1 || core_if.o_seq !== 8'h3C) bad++;
      end
      total++; if (bad !== 0) $display("FAIL bp_stable got %0d bad cycles want 0", bad); else passed++;
      total++; if (xfers !== 0) $display("FAIL bp_no_xfer got %0d want 0", xfers); else passed++;
      ready_en = 1;
      wait_done(50, ok);
      total++; if (!ok) $display("FAIL bp_done_seen got 0 want 1"); else passed++;
      x = sb.pop_front();
      total++; if (best_e !== x.e || count !== x.count) $display("FAIL bp_result got %0d/%0d want %0d/%0d", best_e, count, x.e, x.count); else passed++;
      repeat (2) @(negedge clk);
      total++; if (xfers !== 1 || seq_err !== 0) $display("FAIL bp_one_xfer got %0d/%0d want 1/0", xfers, seq_err); else passed++;
   endtask
   task automatic test_abort();
      exp_t x;
      int n;
      core_e[0] = 16'd50; core_e[1] = 16'd30; core_e[2] = 16'd20; core_e[3] = 16'd10; core_e[4] = 16'd5;
      silent[1] = 1;
      push_exp(0, 0);
      start_sweep(0, 4, 8'h5A);
      clear_mon();
      n = 0;
      while (!(core_if.o_ready === 1'b1 && core_if.o_offset === 7'd1) && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++; if (core_if.o_ready !== 1'b1) $display("FAIL abort_reach_wait got %b want 1", core_if.o_ready); else passed++;
      abort_p = 1;
      @(negedge clk);
      abort_p = 0;
      total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
      total++; if ({core_if.o_valid, core_if.o_ready} !== 2'b00) $display("FAIL abort_handshake got %b want 00", {core_if.o_valid, core_if.o_ready}); else passed++;
      total++; if (core_if.o_core_rst !== 1'b1) $display("FAIL abort_core_rst got %b want 1", core_if.o_core_rst); else passed++;
      @(negedge clk);
      total++; if (core_if.o_core_rst !== 1'b0) $display("FAIL abort_core_rst_drop got %b want 0", core_if.o_core_rst); else passed++;
      repeat (3) @(negedge clk);
      x = sb.pop_front();
      total++; if (done_cnt !== 0) $display("FAIL abort_no_done got %0d want 0", done_cnt); else passed++;
      total++; if (count !== x.count) $display("FAIL abort_count got %0d want %0d", count, x.count); else passed++;
      total++; if (best_e !== x.e || best_ofs !== x.ofs) $display("FAIL abort_partial got %0d@%0d want %0d@%0d", best_e, best_ofs, x.e, x.ofs); else passed++;
      silent[1] = 0;
   endtask
   task automatic test_random_ties();
      exp_t x;
      bit ok;
      for (int o = 60; o <= 67; o++) core_e[o] = 16'($urandom_range(0, 3));
      clear_mon();
      push_exp(60, 67);
      start_sweep(60, 67, 8'h99);
      wait_done(400, ok);
      total++; if (!ok) $display("FAIL rand_done_seen got 0 want 1"); else passed++;
      x = sb.pop_front();
      total++; if (count !== x.count) $display("FAIL rand_count got %0d want %0d", count, x.count); else passed++;
      total++; if (best_e !== x.e || best_ofs !== x.ofs) $display("FAIL rand_best got %0d@%0d want %0d@%0d", best_e, best_ofs, x.e, x.ofs); else passed++;
      repeat (2) @(negedge clk);
   endtask
`ifdef SWEEP_TIMEOUT_EN
   task automatic test_timeout();
      exp_t x;
      bit ok;
      core_e[0] = 16'd50; core_e[2] = 16'd60;
      silent[1] = 1;
      push_exp(0, 2);
      start_sweep(0, 2, 8'h44);
      wait_done(200, ok);
      total++; if (!ok) $display("FAIL to_done_seen got 0 want 1"); else passed++;
      x = sb.pop_front();
      total++; if (timeout !== x.to) $display("FAIL to_flag got %b want %b", timeout, x.to); else passed++;
      total++; if (count !== x.count) $display("FAIL to_count got %0d want %0d", count, x.count); else passed++;
      total++; if (best_e !== x.e || best_ofs !== x.ofs) $display("FAIL to_best got %0d@%0d want %0d@%0d", best_e, best_ofs, x.e, x.ofs); else passed++;
      silent[1] = 0;
      repeat (2) @(negedge clk);
   endtask
`endif
   initial begin
      passed = 0;
      total = 0;
      rst_n = 0;
      start = 0;
      abort_p = 0;
      ofs_first = 0;
      ofs_last = 0;
      seq = 0;
      exp_seq = 0;
      ready_en = 1;
      for (int i = 0; i < 128; i++) core_e[i] = 16'hFFFF;
      clear_mon();
      test_reset();
      test_basic();
      test_top_offset();
      test_empty_range();
      test_backpressure();
      test_abort();
      test_random_ties();
`ifdef SWEEP_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
